// File: rtl/conbox_cfg_loader.sv
// rtl/conbox_cfg_loader.sv - Serialises packed config words into the dual-bank conbox shift chains
//
// Each accepted word carries HALF bits for chain A (low half) and HALF bits
// for chain B (high half). Both halves are shifted out LSB first, in lockstep,
// one bit per cycle while cfg_en is high. A load stops after exactly
// CHAIN_LEN shifts. Any tail bits left in the last word are dropped.
//
// Ports:
//   clk, nrst              clock, asynchronous active-low reset
//   start                  pulse: begin a load (honoured in IDLE or DONE only)
//   abort                  pulse: cancel the load and return to IDLE
//   in_valid/in_ready      word handshake (in_ready high only in FETCH)
//   in_data[WORD_W-1:0]    [HALF-1:0] -> chain A, [WORD_W-1:HALF] -> chain B
//   cfg_en                 shift enable shared by both chains
//   cfg_data_a/cfg_data_b  serial bit into chain A / chain B
//   busy                   high in FETCH or SHIFT
//   done                   high in DONE, held until the next start or abort
//   bit_count              shifts completed in the current load

module conbox_cfg_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 120
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           in_valid,
    input  logic [WORD_W-1:0]              in_data,
    output logic                           in_ready,
    output logic                           cfg_en,
    output logic                           cfg_data_a,
    output logic                           cfg_data_b,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
);

    localparam int HALF  = WORD_W / 2;
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    // A one-bit sub-counter is still needed when HALF is 1 ($clog2(1) is 0).
    localparam int SUB_W = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [HALF-1:0]   buf_a;
    logic [HALF-1:0]   buf_b;
    logic [SUB_W-1:0]  sub;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            buf_a     <= '0;
            buf_b     <= '0;
            sub       <= '0;
            bit_count <= '0;
        end else if (abort) begin
            // Any word in flight is dropped. The chains keep whatever was
            // already shifted in, so the host must do a full reload.
            state     <= IDLE;
            sub       <= '0;
            bit_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FETCH;
                        bit_count <= '0;
                    end
                end
                FETCH: begin
                    // in_ready is high for the whole of FETCH, so in_valid
                    // alone completes the handshake. Stalls of any length are
                    // legal; the chains simply hold.
                    if (in_valid) begin
                        buf_a <= in_data[HALF-1:0];
                        buf_b <= in_data[WORD_W-1:HALF];
                        sub   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    buf_a     <= buf_a >> 1;
                    buf_b     <= buf_b >> 1;
                    sub       <= sub + SUB_W'(1);
                    bit_count <= bit_count + CNT_W'(1);
                    // The chain-length limit takes precedence over the word
                    // boundary, so unused tail bits of the last word are
                    // never shifted.
                    if (bit_count == LAST_BIT) begin
                        state <= DONE;
                    end else if (sub == LAST_SUB) begin
                        state <= FETCH;
                    end
                end
                DONE: begin
                    if (start) begin
                        state     <= FETCH;
                        bit_count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from the state register, so an asynchronous
    // reset drops cfg_en without waiting for a clock edge.
    assign in_ready   = (state == FETCH);
    assign cfg_en     = (state == SHIFT);
    assign cfg_data_a = (state == SHIFT) & buf_a[0];
    assign cfg_data_b = (state == SHIFT) & buf_b[0];
    assign busy       = (state == FETCH) || (state == SHIFT);
    assign done       = (state == DONE);

endmodule
